// File: rtl/vga_sdram_read_bridge.sv
// Line-read bridge from the VGA pixel-cache adapter to the SDRAM controller.
// Each miss is fetched as one 8-beat burst. A one-line hit register and a one-entry pending slot sit in front of SDRAM.
module vga_sdram_read_bridge #(
    parameter int unsigned BURST_LEN = 8,
    parameter int unsigned DATA_W    = 16
) (
    input  logic                        iclk_50,
    input  logic                        ireset,
    input  logic                        iread_req,
    input  logic [21:0]                 iread_address,
    output logic [BURST_LEN*DATA_W-1:0] oread_data,
    output logic                        oread_ack,
    output logic                        oburst_req,
    output logic [24:0]                 oburst_address,
    input  logic                        iburst_grant,
    input  logic [DATA_W-1:0]           iburst_data,
    input  logic                        iburst_valid
);
    localparam int unsigned LINE_W = BURST_LEN * DATA_W;
    localparam int unsigned ADDR_W = 22;
    localparam int unsigned CNT_W  = $clog2(BURST_LEN);
    localparam int unsigned IDX_W  = $clog2(LINE_W);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_COLLECT = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]   hit_addr_q, hit_addr_d;
    logic                hit_valid_q, hit_valid_d;
    logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
    logic                pend_valid_q, pend_valid_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [LINE_W-1:0]   data_q, data_d;
    logic                ack_q;
    logic                breq_q;
    logic [24:0]         baddr_q;

    logic                req_other;
    logic                pend_eff_valid;
    logic [ADDR_W-1:0]   pend_eff_addr;
    logic [IDX_W-1:0]    beat_lsb;

    // Next-state and datapath updates
    always_comb begin
        state_d        = state_q;
        cur_addr_d     = cur_addr_q;
        hit_addr_d     = hit_addr_q;
        hit_valid_d    = hit_valid_q;
        pend_addr_d    = pend_addr_q;
        pend_valid_d   = pend_valid_q;
        beat_cnt_d     = beat_cnt_q;
        line_d         = line_q;
        data_d         = data_q;
        beat_lsb       = IDX_W'(beat_cnt_q) * IDX_W'(DATA_W);

        // A request this cycle for a different line overrides the slot (last wins)
        req_other      = iread_req && (iread_address != cur_addr_q);
        pend_eff_valid = pend_valid_q;
        pend_eff_addr  = pend_addr_q;
        if (req_other) begin
            pend_eff_valid = 1'b1;
            pend_eff_addr  = iread_address;
        end

        case (state_q)
            ST_IDLE: begin
                if (iread_req) begin
                    if (hit_valid_q && (iread_address == hit_addr_q)) begin
                        state_d = ST_ACK;
                    end else begin
                        cur_addr_d = iread_address;
                        state_d    = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                pend_valid_d = pend_eff_valid;
                pend_addr_d  = pend_eff_addr;
                if (iburst_grant) begin
                    beat_cnt_d = '0;
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                pend_valid_d = pend_eff_valid;
                pend_addr_d  = pend_eff_addr;
                if (iburst_valid) begin
                    line_d[beat_lsb +: DATA_W] = iburst_data;
                    beat_cnt_d                 = beat_cnt_q + CNT_W'(1);
                    if (beat_cnt_q == LAST_BEAT) begin
                        data_d       = line_d;
                        hit_addr_d   = cur_addr_q;
                        hit_valid_d  = 1'b1;
                        pend_valid_d = 1'b0;
                        // A newer line supersedes this one: refetch without acking
                        if (pend_eff_valid && (pend_eff_addr != cur_addr_q)) begin
                            cur_addr_d = pend_eff_addr;
                            state_d    = ST_REQ;
                        end else begin
                            state_d = ST_ACK;
                        end
                    end
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; outputs follow the next state
    always_ff @(posedge iclk_50) begin
        if (ireset) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            hit_addr_q   <= '0;
            hit_valid_q  <= 1'b0;
            pend_addr_q  <= '0;
            pend_valid_q <= 1'b0;
            beat_cnt_q   <= '0;
            line_q       <= '0;
            data_q       <= '0;
            ack_q        <= 1'b0;
            breq_q       <= 1'b0;
            baddr_q      <= '0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            hit_addr_q   <= hit_addr_d;
            hit_valid_q  <= hit_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
            beat_cnt_q   <= beat_cnt_d;
            line_q       <= line_d;
            data_q       <= data_d;
            ack_q        <= (state_d == ST_ACK);
            breq_q       <= (state_d == ST_REQ);
            if (state_d == ST_REQ) begin
                baddr_q <= {cur_addr_d, CNT_W'(0)};
            end
        end
    end

    assign oread_data     = data_q;
    assign oread_ack      = ack_q;
    assign oburst_req     = breq_q;
    assign oburst_address = baddr_q;

endmodule

// File: tb/tb_vga_sdram_read_bridge.sv
// Bench for vga_sdram_read_bridge: randomized line reads against a line-level
// memory model, with expected acks and bursts checked by a separate monitor.
module tb_vga_sdram_read_bridge;

    typedef struct {
        logic [127:0] line;
        bit           hit;
        int           ack_edge;
    } exp_t;

    logic         clk = 1'b0;
    logic         ireset;
    logic         iread_req;
    logic [21:0]  iread_address;
    logic [127:0] oread_data;
    logic         oread_ack;
    logic         oburst_req;
    logic [24:0]  oburst_address;
    logic         iburst_grant;
    logic [15:0]  iburst_data;
    logic         iburst_valid;

    int n_chk = 0;
    int n_fail = 0;
    int edge_cnt = 0;
    int last_beat_edge = 0;

    exp_t         exp_q[$];
    logic [24:0]  bq[$];
    logic [21:0]  ext_q[$];
    int           ext_gap = -1;
    bit           poke_ack = 1'b0;
    bit           hit_valid_m = 1'b0;
    logic [21:0]  hit_addr_m = '0;
    logic [15:0]  mem_ovr [int unsigned];
    bit           mon_grant_prev = 1'b0;

    vga_sdram_read_bridge dut (
        .iclk_50        (clk),
        .ireset         (ireset),
        .iread_req      (iread_req),
        .iread_address  (iread_address),
        .oread_data     (oread_data),
        .oread_ack      (oread_ack),
        .oburst_req     (oburst_req),
        .oburst_address (oburst_address),
        .iburst_grant   (iburst_grant),
        .iburst_data    (iburst_data),
        .iburst_valid   (iburst_valid)
    );

    initial forever #10 clk = ~clk;

    initial forever begin
        @(posedge clk);
        edge_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: run still active, required to finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // SDRAM contents: hashed per word address unless overridden
    function automatic logic [15:0] mem_word(input int unsigned w);
        if (mem_ovr.exists(w)) return mem_ovr[w];
        return 16'((w * 32'h9E3779B1) >> 11) ^ 16'(w);
    endfunction

    function automatic logic [127:0] line_of(input logic [21:0] a);
        logic [127:0] l;
        l = '0;
        for (int k = 0; k < 8; k++) l[16*k +: 16] = mem_word(32'({a, 3'b000}) + 32'(k));
        return l;
    endfunction

    function automatic logic [21:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 22'($urandom);
        return 22'($urandom_range(0, 5));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        iburst_valid = 1'($urandom);
        iburst_data  = 16'($urandom);
    endtask

    // Controller model: grant after gdelay cycles, then 8 beats with gaps
    task automatic serve_burst(input int gmode, input int gdelay, input int rst_beat);
        int waited;
        int g;
        logic [24:0] wa;
        waited = 0;
        while (!oburst_req && waited < 60) begin
            junk();
            tick();
            waited++;
        end
        if (!oburst_req) begin
            n_chk++;
            n_fail++;
            $display("FAIL burst_req_timeout: oburst_req low after %0d cycles, required high", waited);
            iburst_valid = 1'b0;
            return;
        end
        repeat (gdelay) begin junk(); tick(); end
        wa = oburst_address;
        iburst_grant = 1'b1;
        junk();
        tick();
        iburst_grant = 1'b0;
        for (int k = 0; k < 8; k++) begin
            g = (gmode == 0) ? 0 : (gmode == 1) ? ((k == 0) ? 0 : 2) : int'($urandom_range(0, 2));
            repeat (g) begin
                iburst_valid = 1'b0;
                iburst_data  = 16'($urandom);
                tick();
            end
            iburst_valid = 1'b1;
            iburst_data  = mem_word(32'(wa) + 32'(k));
            if (k == rst_beat) begin
                ireset = 1'b1;
                exp_q.delete();
                bq.delete();
                hit_valid_m = 1'b0;
            end
            last_beat_edge = edge_cnt + 1;
            tick();
            if (k == rst_beat) begin
                check("rst_burst_req", 128'(oburst_req), 128'(0));
                check("rst_ack", 128'(oread_ack), 128'(0));
                check("rst_data", oread_data, 128'(0));
                ireset = 1'b0;
            end
        end
        iburst_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            junk();
            tick();
            t++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL ack_timeout: %0d acks outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) begin junk(); tick(); end
        iburst_valid = 1'b0;
    endtask

    // One adapter transaction: the request, optional extra requests mid-burst, then the ack
    task automatic txn(input logic [21:0] a, input int gmode, input int gdelay);
        exp_t e;
        logic [21:0] fin;
        if (hit_valid_m && a == hit_addr_m) begin
            e.line = line_of(a);
            e.hit = 1'b1;
            e.ack_edge = edge_cnt + 1;
            exp_q.push_back(e);
            iread_req = 1'b1;
            iread_address = a;
            tick();
            iread_req = 1'b0;
            if (poke_ack) begin
                iread_req = 1'b1;
                iread_address = 22'h3F;
                tick();
                iread_req = 1'b0;
            end
        end else begin
            fin = a;
            foreach (ext_q[i]) if (ext_q[i] != a) fin = ext_q[i];
            bq.push_back({a, 3'b000});
            if (fin != a) bq.push_back({fin, 3'b000});
            e.line = line_of(fin);
            e.hit = 1'b0;
            e.ack_edge = 0;
            exp_q.push_back(e);
            iread_req = 1'b1;
            iread_address = a;
            fork
                begin
                    tick();
                    iread_req = 1'b0;
                    foreach (ext_q[i]) begin
                        repeat ((ext_gap >= 0) ? ext_gap : int'($urandom_range(0, 1))) tick();
                        iread_req = 1'b1;
                        iread_address = ext_q[i];
                        tick();
                        iread_req = 1'b0;
                    end
                end
                begin
                    serve_burst(gmode, gdelay, -1);
                    if (fin != a) serve_burst(gmode, gdelay, -1);
                end
            join
            hit_valid_m = 1'b1;
            hit_addr_m = fin;
        end
        wait_idle();
    endtask

    // Monitor: pops expected acks and burst addresses as the DUT presents them
    initial begin
        exp_t e;
        logic [24:0] ba;
        forever begin
            @(negedge clk);
            if (ireset) begin
                mon_grant_prev = 1'b0;
                continue;
            end
            if (mon_grant_prev) check("burst_req_drop", 128'(oburst_req), 128'(0));
            mon_grant_prev = 1'b0;
            if (oread_ack) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_ack: ack with data %0h, required no ack", oread_data);
                end else begin
                    e = exp_q.pop_front();
                    check("ack_data", oread_data, e.line);
                    check("ack_cycle", 128'(edge_cnt), 128'(e.hit ? e.ack_edge : last_beat_edge));
                end
            end
            if (oburst_req) begin
                n_chk++;
                if (bq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_burst_req: address %0h, required no request", oburst_address);
                end else if (iburst_grant) begin
                    ba = bq.pop_front();
                    check("burst_address", 128'(oburst_address), 128'(ba));
                    mon_grant_prev = 1'b1;
                end
            end
        end
    end

    initial begin
        ireset = 1'b1;
        iread_req = 1'b0;
        iread_address = '0;
        iburst_grant = 1'b0;
        iburst_valid = 1'b0;
        iburst_data = '0;
        repeat (3) tick();
        ireset = 1'b0;

        // Idle after reset: beats outside a burst must not disturb anything
        for (int i = 0; i < 20; i++) begin
            junk();
            tick();
            check("idle_ack", 128'(oread_ack), 128'(0));
            check("idle_burst_req", 128'(oburst_req), 128'(0));
            check("idle_data", oread_data, 128'(0));
            check("idle_burst_addr", 128'(oburst_address), 128'(0));
        end
        iburst_valid = 1'b0;

        // Single miss on line 5 with beats 0..7
        for (int k = 0; k < 8; k++) mem_ovr[32'h28 + 32'(k)] = 16'(k);
        ext_q.delete();
        txn(22'h000005, 0, 2);
        check("single_miss_line", oread_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);

        // Hit on the same line; a request during the ack cycle is dropped
        poke_ack = 1'b1;
        txn(22'h000005, 0, 0);
        poke_ack = 1'b0;
        check("hit_line", oread_data, 128'h0007_0006_0005_0004_0003_0002_0001_0000);

        // Superseded line: 0x10 then 0x11, 0x12 while collecting
        ext_q.delete();
        ext_q.push_back(22'h11);
        ext_q.push_back(22'h12);
        ext_gap = 1;
        txn(22'h10, 0, 0);
        ext_gap = -1;
        ext_q.delete();

        // Valid every third cycle
        txn(22'h07, 1, 1);

        // Reset on the 4th beat, then the old hit line must miss
        txn(22'h10, 0, 1);
        bq.push_back({22'h30, 3'b000});
        iread_req = 1'b1;
        iread_address = 22'h30;
        fork
            begin tick(); iread_req = 1'b0; end
            serve_burst(0, 1, 3);
        join
        wait_idle();
        txn(22'h10, 0, 0);

        // Random traffic with hits, misses and superseding requests
        for (int t = 0; t < 40; t++) begin
            logic [21:0] a;
            int n;
            a = pick_addr();
            n = int'($urandom_range(0, 3));
            ext_q.delete();
            for (int j = 0; j < n; j++) ext_q.push_back(pick_addr());
            txn(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end
        ext_q.delete();

        check("acks_outstanding", 128'(exp_q.size()), 128'(0));
        check("bursts_outstanding", 128'(bq.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sdram_read_bridge.md
# vga_sdram_read_bridge

Sits between the VGA pixel-cache adapter and the SDRAM controller on the 50 MHz domain. It accepts 22-bit line-address read requests from the adapter, issues an 8-beat burst read on the controller's 16-bit read port, assembles the beats into one 128-bit line, and acknowledges the adapter with the line. A one-line hit register returns repeated requests without touching SDRAM. A one-entry pending slot absorbs requests that arrive while a burst is in flight.

## Interface
- BURST_LEN, 8, beats per line (fixed: BURST_LEN*DATA_W = 128)
- DATA_W, 16, SDRAM controller read data width
- iclk_50  in  1  clock; all logic on rising edge
- ireset  in  1  synchronous, active-high reset
- iread_req  in  1  adapter read request (level or pulse; sampled every cycle)
- iread_address  in  22  adapter line address (128-bit units)
- oread_data  out  128  assembled line; stable between acks
- oread_ack  out  1  one-cycle pulse, oread_data valid this cycle
- oburst_req  out  1  burst request to SDRAM controller, held until granted
- oburst_address  out  25  word address = {line address, 3'b000}
- iburst_grant  in  1  one-cycle controller acceptance of oburst_req
- iburst_data  in  16  read beat
- iburst_valid  in  1  beat strobe; gaps between beats allowed

## Operation
- State machine: IDLE, REQ, COLLECT, ACK.
- IDLE, iread_req=1:
  - Hit (hit_valid and iread_address == hit_addr): go to ACK.
  - Miss: latch the address into cur_addr and go to REQ.
- REQ:
  - oburst_req=1 and oburst_address={cur_addr,3'b000}, held until iburst_grant.
  - On grant: beat counter = 0, go to COLLECT. oburst_req drops in the cycle after the grant.
- COLLECT:
  - Each iburst_valid writes beat k to line[16k+15:16k]; the first beat is the LSBs.
  - The 8th beat (counter == 7 with valid) writes the line into the data register, sets hit_addr = cur_addr and hit_valid = 1.
  - Next state after the 8th beat:
    - pending slot empty, or pending address == cur_addr: clear the slot, go to ACK.
    - pending address differs: cur_addr = pending address, clear the slot, go to REQ. No ack is issued for the superseded line.
- ACK: oread_ack=1 for exactly one cycle, then IDLE.
- Requests while in REQ or COLLECT:
  - Address == cur_addr: absorbed.
  - Any other address: written to the pending slot (last wins).
- Requests while in ACK: ignored. The adapter re-requests if it still needs data.
- iburst_valid outside COLLECT: ignored (no state change, no data write).
- Beat counter is 3 bits and wraps only through reset or a new burst. It never advances outside COLLECT.
- oburst_address arithmetic: zero-extended concatenation, no overflow possible.

## Timing
- Reset values:
  - oread_ack=0, oburst_req=0, oread_data=0, oburst_address=0.
  - state=IDLE, hit_valid=0, pending slot empty, beat counter=0.
- Reset mid-burst: back to IDLE next edge, oburst_req=0 immediately (registered). Beats still arriving from the controller are ignored.
- Hit latency: request sampled at edge N, oread_ack high in cycle N+1.
- Miss latency:
  - Request at edge N, oburst_req high from cycle N+1.
  - Grant at edge G, beats at edges B1..B8.
  - oread_ack high in cycle B8+1.
  - Minimum with back-to-back beats: 11 cycles if the grant arrives in the first REQ cycle.
- oread_data changes only on the edge that captures the 8th beat. It is stable through ack and afterwards.
- All outputs registered; no combinational input-to-output path.

## Test plan
- Reset then idle: all outputs 0 for 20 cycles, with random iburst_valid/iburst_data toggling.
- Single miss: address 22'h000005, grant 2 cycles after oburst_req, beats 16'h0000..16'h0007 back to back.
  - oburst_address = 25'h000028.
  - oread_data = 128'h0007_0006_0005_0004_0003_0002_0001_0000.
  - One oread_ack pulse, one cycle after the last beat.
- Hit: repeat address 22'h000005 after the above. oread_ack one cycle later, same data, oburst_req stays 0.
- Superseded request:
  - Request 22'h10 and, during COLLECT, request 22'h11 then 22'h12.
  - Required: no ack after the 22'h10 burst; a second oburst_req with address 25'h90; one ack carrying the 22'h12 line.
- Beat gaps: valid asserted every 3rd cycle. Line assembled in correct order; the ack comes one cycle after the 8th valid only.
- Reset on the 4th beat of a burst:
  - IDLE on the next edge, oburst_req=0, no ack.
  - Following request 22'h10 misses (hit_valid cleared) and issues a fresh burst.
